od_distance_multi: RTL and testbench
====================================

# od_distance_multi

Parametrised multi-channel obstacle detector: the successor to the single-channel distance/time-out detector.
- Each channel takes ultrasonic distance samples and echo time-outs, applies near/far hysteresis and N-sample confirmation, and drives a debounced object_detected flag.
- Consecutive time-outs raise a per-channel sensor fault.
- A registered nearest-object report summarises all channels for the downstream motion controller.

## Interface
- NUM_CH, 4, number of sensor channels (1..8)
- DIST_W, 23, distance sample width (unsigned, unit = sensor tick)
- NEAR_THRESH, 100, distance <= this is a "near" sample
- FAR_THRESH, 150, distance > this is a "far" sample; FAR_THRESH >= NEAR_THRESH required
- CONFIRM_CNT, 3, consecutive samples needed to change detect state (1..15)
- TIMEOUT_LIMIT, 4, consecutive time-outs that set sensor_fault (1..15)
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- distance  in  NUM_CH*DIST_W  packed samples, channel i at [i*DIST_W +: DIST_W]
- meas_valid  in  NUM_CH  one-cycle strobe, distance[i] valid
- time_out  in  NUM_CH  one-cycle strobe, no echo received on channel i
- object_detected  out  NUM_CH  debounced detect flag per channel
- sensor_fault  out  NUM_CH  channel has hit TIMEOUT_LIMIT consecutive time-outs
- any_detected  out  1  OR of object_detected
- nearest_ch  out  $clog2(NUM_CH) (min 1)  index of nearest detected channel
- nearest_dist  out  DIST_W  last valid distance of that channel
- nearest_valid  out  1  nearest_ch/nearest_dist meaningful

## Operation
- Sample classification per channel, per cycle:
  - time_out=1: TIMEOUT, which counts as a far event. time_out wins over a simultaneous meas_valid.
  - meas_valid=1 with distance==0: glitch. Ignored entirely, no state or counter change.
  - meas_valid=1 with distance <= NEAR_THRESH: NEAR.
  - meas_valid=1 with distance > FAR_THRESH: FAR.
  - Otherwise: BAND.
  - No strobe: idle, all state held.
- Per-channel FSM, with a 4-bit confirm counter cnt:
  - CLEAR: NEAR → PEND_NEAR with cnt=1, or straight to DETECTED if CONFIRM_CNT==1. Others stay in CLEAR.
  - PEND_NEAR: NEAR increments cnt; when cnt reaches CONFIRM_CNT → DETECTED. BAND, FAR or TIMEOUT → CLEAR with cnt=0.
  - DETECTED: FAR or TIMEOUT → PEND_FAR with cnt=1, or straight to CLEAR if CONFIRM_CNT==1. NEAR and BAND stay in DETECTED.
  - PEND_FAR: FAR or TIMEOUT increments cnt; when cnt reaches CONFIRM_CNT → CLEAR. NEAR or BAND → DETECTED with cnt=0.
- object_detected[i] = 1 in DETECTED and PEND_FAR.
- Fault counter, per channel, saturating at TIMEOUT_LIMIT:
  - TIMEOUT increments it; any non-glitch meas_valid clears it to 0.
  - sensor_fault[i] = (counter == TIMEOUT_LIMIT).
- last_dist[i] loads on every non-glitch meas_valid; it is not updated by TIMEOUT.
- Nearest report:
  - Over channels with object_detected=1, pick the minimum last_dist. On equal distances the lowest index wins.
  - With no channel detected: nearest_valid=0 and nearest_ch/nearest_dist are held at their previous values.
- Reset (asynchronous, any time including mid-confirmation):
  - All FSMs → CLEAR; cnt, fault counters and last_dist cleared.
  - All outputs 0.

## Timing
- Per-channel FSM state, object_detected and sensor_fault are registered. Each changes on the clk edge that samples the deciding strobe, i.e. 1-cycle latency from the strobe.
- any_detected is combinational from the object_detected registers: same cycle as object_detected.
- The nearest_* outputs are registered from the object_detected and last_dist registers: 1 cycle after object_detected.
- Back-to-back strobes every cycle are supported; there is no handshake and no back-pressure.
- Channels are fully independent; simultaneous events on different channels need no arbitration.

## Configuration
- OD_FAILSAFE_EN defined: while sensor_fault[i]=1, object_detected[i] is forced to 1 (fail-safe stop). This feeds any_detected and the nearest report, using last_dist[i]. The FSM keeps running underneath, and the force drops on the cycle after the fault clears.
- OD_FAILSAFE_EN undefined: sensor_fault is a status flag only, and object_detected follows the FSM alone.

## Structure
- Package od_pkg:
  - state enum od_state_e {CLEAR, PEND_NEAR, DETECTED, PEND_FAR};
  - sample-class enum {IDLE, GLITCH, NEAR, BAND, FAR, TIMEOUT};
  - the 4-bit counter width constant.
- Sub-module od_channel_fsm: one channel's classifier, FSM, confirm counter, fault counter and last_dist register. Instantiated NUM_CH times via generate.
- Top level holds the min-reduction and the nearest_* registers.

## Test plan
All scenarios use the default parameters (NEAR=100, FAR=150, CONFIRM=3, TIMEOUT_LIMIT=4).
- Reset release, then ch0 receives three meas_valid strobes with distance=80 → object_detected[0] rises 1 cycle after the 3rd strobe; nearest_valid=1, nearest_ch=0, nearest_dist=80 one cycle later.
- ch0 detected, then samples 200, 200, 120, 200, 200, 200 → object_detected[0] stays 1 through the BAND-induced restart and falls 1 cycle after the final 200.
- ch1 receives distance=0 strobes interleaved between 90, 90, 90 → the glitches are ignored and detection still confirms on the 3rd 90.
- ch2 receives four time_out strobes → sensor_fault[2]=1 after the 4th. With OD_FAILSAFE_EN, object_detected[2]=1. One meas_valid with distance=300 clears the fault.
- ch1=70 and ch3=70 both detected → nearest_ch=1 (tie, lowest index wins). ch1 then goes far → nearest_ch=3.
- rst asserted asynchronously mid-PEND_NEAR (cnt=2) → all outputs 0 immediately. After release a single 80 sample does not detect.

Source files
------------

// File: rtl/od_pkg.sv
// Shared types for the multi-channel obstacle detector: FSM states, sample classes
// and the confirm/fault counter width.
package od_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        CLEAR,
        PEND_NEAR,
        DETECTED,
        PEND_FAR
    } od_state_e;

    typedef enum logic [2:0] {
        IDLE,
        GLITCH,
        NEAR,
        BAND,
        FAR,
        TIMEOUT
    } od_sample_e;

endpackage

// File: rtl/od_channel_fsm.sv
// One detector channel: sample classifier, hysteresis/confirm FSM, time-out fault counter
// and last-distance register. OD_FAILSAFE_EN forces object_detected while sensor_fault is set.
module od_channel_fsm
    import od_pkg::*;
#(
    parameter int DIST_W        = 23,
    parameter int NEAR_THRESH   = 100,
    parameter int FAR_THRESH    = 150,
    parameter int CONFIRM_CNT   = 3,
    parameter int TIMEOUT_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIST_W-1:0] distance,
    input  logic              meas_valid,
    input  logic              time_out,
    output logic              object_detected,
    output logic              sensor_fault,
    output logic [DIST_W-1:0] last_dist
);

    localparam logic [DIST_W-1:0] NEAR_V    = DIST_W'(NEAR_THRESH);
    localparam logic [DIST_W-1:0] FAR_V     = DIST_W'(FAR_THRESH);
    localparam logic [CNT_W-1:0]  CONFIRM_V = CNT_W'(CONFIRM_CNT);
    localparam logic [CNT_W-1:0]  LIMIT_V   = CNT_W'(TIMEOUT_LIMIT);

    od_sample_e             cls;
    od_state_e              state;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       fault_cnt;
    logic [CNT_W-1:0]       fault_n;
    logic                   fsm_det;
    logic                   far_ev;
    logic                   meas_ok;

    // A time-out masks any measurement arriving in the same cycle.
    always_comb begin
        cls = IDLE;
        if (time_out) begin
            cls = TIMEOUT;
        end else if (meas_valid) begin
            if (distance == '0)
                cls = GLITCH;
            else if (distance <= NEAR_V)
                cls = NEAR;
            else if (distance > FAR_V)
                cls = FAR;
            else
                cls = BAND;
        end
    end

    assign far_ev  = (cls == FAR) || (cls == TIMEOUT);
    assign meas_ok = (cls == NEAR) || (cls == BAND) || (cls == FAR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLEAR;
            cnt     <= '0;
            fsm_det <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    if (cls == NEAR) begin
                        if (CONFIRM_V == CNT_W'(1)) begin
                            state   <= DETECTED;
                            fsm_det <= 1'b1;
                        end else begin
                            state <= PEND_NEAR;
                            cnt   <= CNT_W'(1);
                        end
                    end
                end
                PEND_NEAR: begin
                    if (cls == NEAR) begin
                        if (cnt + CNT_W'(1) == CONFIRM_V) begin
                            state   <= DETECTED;
                            cnt     <= '0;
                            fsm_det <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end else if ((cls == BAND) || far_ev) begin
                        state <= CLEAR;
                        cnt   <= '0;
                    end
                end
                DETECTED: begin
                    if (far_ev) begin
                        if (CONFIRM_V == CNT_W'(1)) begin
                            state   <= CLEAR;
                            fsm_det <= 1'b0;
                        end else begin
                            state <= PEND_FAR;
                            cnt   <= CNT_W'(1);
                        end
                    end
                end
                PEND_FAR: begin
                    if (far_ev) begin
                        if (cnt + CNT_W'(1) == CONFIRM_V) begin
                            state   <= CLEAR;
                            cnt     <= '0;
                            fsm_det <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end else if ((cls == NEAR) || (cls == BAND)) begin
                        state <= DETECTED;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state   <= CLEAR;
                    cnt     <= '0;
                    fsm_det <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of consecutive time-outs; any real measurement restarts it.
    always_comb begin
        fault_n = fault_cnt;
        if (cls == TIMEOUT) begin
            if (fault_cnt != LIMIT_V)
                fault_n = fault_cnt + CNT_W'(1);
        end else if (meas_ok) begin
            fault_n = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_cnt    <= '0;
            sensor_fault <= 1'b0;
            last_dist    <= '0;
        end else begin
            fault_cnt    <= fault_n;
            sensor_fault <= (fault_n == LIMIT_V);
            if (meas_ok)
                last_dist <= distance;
        end
    end

`ifdef OD_FAILSAFE_EN
    assign object_detected = fsm_det | sensor_fault;
`else
    assign object_detected = fsm_det;
`endif

endmodule

// File: rtl/od_distance_multi.sv
// Multi-channel obstacle detector top: per-channel detectors plus a registered
// nearest-object report. Optional macro OD_FAILSAFE_EN (handled in od_channel_fsm).
module od_distance_multi
    import od_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int DIST_W        = 23,
    parameter int NEAR_THRESH   = 100,
    parameter int FAR_THRESH    = 150,
    parameter int CONFIRM_CNT   = 3,
    parameter int TIMEOUT_LIMIT = 4,
    localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*DIST_W-1:0] distance,
    input  logic [NUM_CH-1:0]        meas_valid,
    input  logic [NUM_CH-1:0]        time_out,
    output logic [NUM_CH-1:0]        object_detected,
    output logic [NUM_CH-1:0]        sensor_fault,
    output logic                     any_detected,
    output logic [CH_W-1:0]          nearest_ch,
    output logic [DIST_W-1:0]        nearest_dist,
    output logic                     nearest_valid
);

    logic [DIST_W-1:0] last_dist [NUM_CH];
    logic              found;
    logic [CH_W-1:0]   best_ch;
    logic [DIST_W-1:0] best_dist;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        od_channel_fsm #(
            .DIST_W        (DIST_W),
            .NEAR_THRESH   (NEAR_THRESH),
            .FAR_THRESH    (FAR_THRESH),
            .CONFIRM_CNT   (CONFIRM_CNT),
            .TIMEOUT_LIMIT (TIMEOUT_LIMIT)
        ) u_ch (
            .clk             (clk),
            .rst             (rst),
            .distance        (distance[g*DIST_W +: DIST_W]),
            .meas_valid      (meas_valid[g]),
            .time_out        (time_out[g]),
            .object_detected (object_detected[g]),
            .sensor_fault    (sensor_fault[g]),
            .last_dist       (last_dist[g])
        );
    end

    assign any_detected = |object_detected;

    // Strict less-than keeps the lowest index on equal distances.
    always_comb begin
        found     = 1'b0;
        best_ch   = '0;
        best_dist = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (object_detected[i] && (!found || (last_dist[i] < best_dist))) begin
                found     = 1'b1;
                best_ch   = CH_W'(i);
                best_dist = last_dist[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nearest_valid <= 1'b0;
            nearest_ch    <= '0;
            nearest_dist  <= '0;
        end else begin
            nearest_valid <= found;
            if (found) begin
                nearest_ch   <= best_ch;
                nearest_dist <= best_dist;
            end
        end
    end

endmodule

// File: tb/tb_od_distance_multi.sv
// Directed self-checking bench for od_distance_multi with default parameters;
// expectations for ch2/ch0 faults adapt when OD_FAILSAFE_EN is defined.
module tb_od_distance_multi;

    localparam int NUM_CH = 4;
    localparam int DIST_W = 23;

    logic                     clk;
    logic                     rst;
    logic [NUM_CH*DIST_W-1:0] distance;
    logic [NUM_CH-1:0]        meas_valid;
    logic [NUM_CH-1:0]        time_out;
    logic [NUM_CH-1:0]        object_detected;
    logic [NUM_CH-1:0]        sensor_fault;
    logic                     any_detected;
    logic [1:0]               nearest_ch;
    logic [DIST_W-1:0]        nearest_dist;
    logic                     nearest_valid;

    int vectors;
    int miscompares;

    od_distance_multi dut (
        .clk             (clk),
        .rst             (rst),
        .distance        (distance),
        .meas_valid      (meas_valid),
        .time_out        (time_out),
        .object_detected (object_detected),
        .sensor_fault    (sensor_fault),
        .any_detected    (any_detected),
        .nearest_ch      (nearest_ch),
        .nearest_dist    (nearest_dist),
        .nearest_valid   (nearest_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: drives one strobe for a single cycle, returns at the next negedge.
    task automatic pulse(input int ch, input logic mv, input logic to, input logic [DIST_W-1:0] d);
        distance                  = '0;
        meas_valid                = '0;
        time_out                  = '0;
        distance[ch*DIST_W +: DIST_W] = d;
        meas_valid[ch]            = mv;
        time_out[ch]              = to;
        @(negedge clk);
        distance   = '0;
        meas_valid = '0;
        time_out   = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        distance    = '0;
        meas_valid  = '0;
        time_out    = '0;

        #12;
        check("rst_od",    32'(object_detected), 32'h0);
        check("rst_fault", 32'(sensor_fault),    32'h0);
        check("rst_any",   32'(any_detected),    32'h0);
        check("rst_nv",    32'(nearest_valid),   32'h0);
        check("rst_nch",   32'(nearest_ch),      32'h0);
        check("rst_ndist", 32'(nearest_dist),    32'h0);
        @(negedge clk);
        rst = 1'b0;

        // ch0 confirms on third near sample
        pulse(0, 1'b1, 1'b0, 23'd80);
        pulse(0, 1'b1, 1'b0, 23'd80);
        check("s1_od_after2", 32'(object_detected), 32'h0);
        pulse(0, 1'b1, 1'b0, 23'd80);
        check("s1_od_after3", 32'(object_detected), 32'h1);
        check("s1_any",       32'(any_detected),    32'h1);
        check("s1_nv_lag",    32'(nearest_valid),   32'h0);
        idle(1);
        check("s1_nv",    32'(nearest_valid), 32'h1);
        check("s1_nch",   32'(nearest_ch),    32'h0);
        check("s1_ndist", 32'(nearest_dist),  32'd80);

        // far run restarted by a band sample
        pulse(0, 1'b1, 1'b0, 23'd200);
        pulse(0, 1'b1, 1'b0, 23'd200);
        pulse(0, 1'b1, 1'b0, 23'd120);
        check("s2_od_band", 32'(object_detected), 32'h1);
        pulse(0, 1'b1, 1'b0, 23'd200);
        pulse(0, 1'b1, 1'b0, 23'd200);
        check("s2_od_far2", 32'(object_detected), 32'h1);
        pulse(0, 1'b1, 1'b0, 23'd200);
        check("s2_od_far3", 32'(object_detected), 32'h0);
        idle(1);
        check("s2_nv_drop",   32'(nearest_valid), 32'h0);
        check("s2_ndist_hold", 32'(nearest_dist), 32'd200);

        // ch1 with interleaved zero-distance glitches
        pulse(1, 1'b1, 1'b0, 23'd90);
        pulse(1, 1'b1, 1'b0, 23'd0);
        pulse(1, 1'b1, 1'b0, 23'd90);
        pulse(1, 1'b1, 1'b0, 23'd0);
        check("s3_od_pre", 32'(object_detected), 32'h0);
        pulse(1, 1'b1, 1'b0, 23'd90);
        check("s3_od", 32'(object_detected), 32'h2);
        idle(1);
        check("s3_nch",   32'(nearest_ch),   32'h1);
        check("s3_ndist", 32'(nearest_dist), 32'd90);

        // tie between ch1 and ch3, then ch1 leaves
        pulse(1, 1'b1, 1'b0, 23'd70);
        pulse(3, 1'b1, 1'b0, 23'd70);
        pulse(3, 1'b1, 1'b0, 23'd70);
        pulse(3, 1'b1, 1'b0, 23'd70);
        check("s5_od_both", 32'(object_detected), 32'hA);
        idle(1);
        check("s5_tie_nch",   32'(nearest_ch),   32'h1);
        check("s5_tie_ndist", 32'(nearest_dist), 32'd70);
        pulse(1, 1'b1, 1'b0, 23'd200);
        pulse(1, 1'b1, 1'b0, 23'd200);
        pulse(1, 1'b1, 1'b0, 23'd200);
        check("s5_od_ch1_gone", 32'(object_detected), 32'h8);
        idle(1);
        check("s5_nch3", 32'(nearest_ch),    32'h3);
        check("s5_nv",   32'(nearest_valid), 32'h1);

        // ch2 time-out fault, saturation and clearing
        pulse(2, 1'b0, 1'b1, 23'd0);
        pulse(2, 1'b0, 1'b1, 23'd0);
        pulse(2, 1'b0, 1'b1, 23'd0);
        check("s4_fault_3", 32'(sensor_fault), 32'h0);
        pulse(2, 1'b0, 1'b1, 23'd0);
        check("s4_fault_4", 32'(sensor_fault), 32'h4);
`ifdef OD_FAILSAFE_EN
        check("s4_od_forced", 32'(object_detected), 32'hC);
`else
        check("s4_od_status", 32'(object_detected), 32'h8);
`endif
        pulse(2, 1'b0, 1'b1, 23'd0);
        check("s4_fault_sat", 32'(sensor_fault), 32'h4);
        pulse(2, 1'b1, 1'b0, 23'd300);
        check("s4_fault_clr", 32'(sensor_fault),    32'h0);
        check("s4_od_clr",    32'(object_detected), 32'h8);

        // simultaneous time_out and near sample: time_out wins
        pulse(0, 1'b1, 1'b1, 23'd80);
        pulse(0, 1'b1, 1'b1, 23'd80);
        pulse(0, 1'b1, 1'b1, 23'd80);
        check("s7_od_to_wins",   32'(object_detected), 32'h8);
        check("s7_fault_pre",    32'(sensor_fault),    32'h0);
        pulse(0, 1'b1, 1'b1, 23'd80);
        check("s7_fault_set",    32'(sensor_fault),    32'h1);
`ifdef OD_FAILSAFE_EN
        check("s7_od_forced", 32'(object_detected), 32'h9);
`else
        check("s7_od_status", 32'(object_detected), 32'h8);
`endif
        pulse(0, 1'b1, 1'b0, 23'd300);
        check("s7_fault_clr", 32'(sensor_fault), 32'h0);

        // asynchronous reset in the middle of a near confirmation
        pulse(0, 1'b1, 1'b0, 23'd80);
        pulse(0, 1'b1, 1'b0, 23'd80);
        #3 rst = 1'b1;
        #1;
        check("s6_od",    32'(object_detected), 32'h0);
        check("s6_any",   32'(any_detected),    32'h0);
        check("s6_nv",    32'(nearest_valid),   32'h0);
        check("s6_nch",   32'(nearest_ch),      32'h0);
        check("s6_ndist", 32'(nearest_dist),    32'h0);
        @(negedge clk);
        rst = 1'b0;
        pulse(0, 1'b1, 1'b0, 23'd80);
        check("s6_od_single", 32'(object_detected), 32'h0);
        idle(1);
        check("s6_nv_after", 32'(nearest_valid), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
